// File: rtl/ser_pkg.sv
// ser_pkg: shared constants and types for the RS-232 serial port (8N1).
//   DIV_DEFAULT   clock cycles per bit at 50 MHz / 115200 baud
//   REG_DATA/STAT word select on bus_addr[2]
//   ST_*          bit positions in the status word
//   ser_state_e   frame FSM encoding, shared by transmitter and receiver
package ser_pkg;

  localparam int unsigned DIV_DEFAULT = 434;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int ST_RXRDY = 0;
  localparam int ST_TXRDY = 1;
  localparam int ST_FERR  = 2;
  localparam int ST_OVR   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/ser_if.sv
// ser_if: RISC5 I/O bus slice seen by the serial port.
//   stb      word selected by the address decoder
//   we       write enable, qualified by stb
//   addr     bus_addr[2]: 0 = data word, 1 = status word
//   data_in  write data (only [7:0] used)
//   data_out combinational read data
//   ack      acknowledge, equal to stb (no wait states)
interface ser_if;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, we, addr, data_in, input data_out, ack);
  modport slave  (input stb, we, addr, data_in, output data_out, ack);
endinterface

// File: rtl/ser_rx.sv
// ser_rx: 8N1 receiver. Synchronises rxd, finds the start bit, samples
// each bit near its centre and reports the completed frame.
//   clk, rst_n    system clock, async active-low reset
//   rxd_i         raw serial line, asynchronous, idle high
//   done_o        one-cycle pulse: frame with valid stop bit, data_o valid
//   frame_err_o   one-cycle pulse: stop bit sampled as 0
//   data_o        received byte (LSB first on the line)
module ser_rx
  import ser_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic       done_o,
  output logic       frame_err_o,
  output logic [7:0] data_o
);

  localparam logic [15:0] FULL_RELOAD = 16'(DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(DIV / 2 - 1);

  logic [1:0] sync_q;
  logic       rxd_s;

  ser_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;

  // Synchroniser resets to the idle level so leaving reset never looks
  // like a falling start edge.
  // NOTE: registers use <= so every flop samples pre-edge values; blocking
  // assignments here would collapse the two synchroniser stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
    end
  end

  assign rxd_s = sync_q[1];

  // NOTE: every control/datapath flop has an async reset so the frame is
  // abandoned cleanly; the byte register is small enough that resetting it
  // also gives a defined rx_byte after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // NOTE: all outputs of this block get a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    done_o      = 1'b0;
    frame_err_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = HALF_RELOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          // Line back high at mid start bit: glitch, not a frame.
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = FULL_RELOAD;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rxd_s, shreg_q[7:1]};
          cnt_d   = FULL_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          // Back to IDLE at once; a low line here re-arms start detection.
          state_d = IDLE;
          if (rxd_s) begin
            done_o = 1'b1;
          end else begin
            frame_err_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_o = shreg_q;

endmodule

// File: rtl/ser.sv
// ser: memory-mapped RS-232 port (8N1, fixed baud) for the RISC5 I/O bus.
// Contains the transmitter, status/data registers and bus decode; the
// receiver lives in ser_rx.
//   clk, rst_n  system clock, async active-low reset
//   bus         ser_if slave: data word (addr 0), status word (addr 1)
//   rxd         serial input, asynchronous, idle high
//   txd         serial output, registered, idle high
module ser
  import ser_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  ser_if.slave bus,
  input  logic rxd,
  output logic txd
);

  localparam logic [15:0] FULL_RELOAD = 16'(DIV - 1);

  // Bus decode; side effects land on the edge that ends the stb cycle.
  logic wr_data, rd_data, rd_stat;
  assign wr_data = bus.stb &  bus.we & (bus.addr == REG_DATA);
  assign rd_data = bus.stb & ~bus.we & (bus.addr == REG_DATA);
  assign rd_stat = bus.stb & ~bus.we & (bus.addr == REG_STAT);

  logic unused_data;
  assign unused_data = ^bus.data_in[31:8];

  // ---------------- transmitter ----------------
  ser_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shreg_q, tx_shreg_d;
  logic        txd_q, txd_d;
  logic        tx_ready;

  assign tx_ready = (tx_state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;

    unique case (tx_state_q)
      IDLE: begin
        // Writes in any other state fall through here and are dropped.
        if (wr_data) begin
          tx_state_d = START;
          tx_cnt_d   = FULL_RELOAD;
          tx_shreg_d = bus.data_in[7:0];
        end
      end
      START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = DATA;
          tx_cnt_d   = FULL_RELOAD;
          tx_idx_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = FULL_RELOAD;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = STOP;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = IDLE;
    endcase

    // Line level is decoded from the next state so txd is a clean flop
    // output aligned with the state register.
    unique case (tx_state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = tx_shreg_d[tx_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  assign txd = txd_q;

  // ---------------- receiver ----------------
  logic       rx_done, rx_ferr;
  logic [7:0] rx_data;

  ser_rx #(.DIV(DIV)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd_i       (rxd),
    .done_o      (rx_done),
    .frame_err_o (rx_ferr),
    .data_o      (rx_data)
  );

  // ---------------- status / data registers ----------------
  logic       rx_ready_q, rx_ready_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rx_ready_q <= rx_ready_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  // Set beats clear everywhere: a new byte outranks a data read, and a
  // flag being raised outranks a status read.
  always_comb begin
    rx_ready_d = rx_ready_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;
    rx_byte_d  = rx_byte_q;

    if (rx_done) begin
      rx_byte_d  = rx_data;
      rx_ready_d = 1'b1;
    end else if (rd_data) begin
      rx_ready_d = 1'b0;
    end

    // Overrun only if the old byte was unread and not being read right now.
    if (rx_done && rx_ready_q && !rd_data) begin
      ovr_d = 1'b1;
    end else if (rd_stat) begin
      ovr_d = 1'b0;
    end

    if (rx_ferr) begin
      ferr_d = 1'b1;
    end else if (rd_stat) begin
      ferr_d = 1'b0;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    bus.data_out = '0;
    if (bus.stb) begin
      if (bus.addr == REG_DATA) begin
        bus.data_out[7:0] = rx_byte_q;
      end else begin
        bus.data_out[ST_RXRDY] = rx_ready_q;
        bus.data_out[ST_TXRDY] = tx_ready;
        bus.data_out[ST_FERR]  = ferr_q;
        bus.data_out[ST_OVR]   = ovr_q;
      end
    end
  end

  assign bus.ack = bus.stb;

endmodule
